// File: rtl/serial_subtractor_pkg.sv
// serial_arith_pkg: shared FSM state encoding and counter sizing for the bit-serial arithmetic blocks
package serial_arith_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result valid-ready bundle for the serial subtractor
interface serial_subtractor_if #(parameter int N = 6);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] d;
  logic         bout;
  logic         busy;
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, busy
  );
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, busy
  );
endinterface

// File: rtl/serial_subtractor_fa_cell.sv
// fa_cell: combinational 1-bit full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial d = a - b - bin using one full-adder cell over N clocks
import serial_arith_pkg::*;
module serial_subtractor #(parameter int N = 6) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave io
);
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_sr, nb_sr, d_sr, d;
  logic          carry, out_valid, bout, s, cout;
  fa_cell u_fa (.a(a_sr[0]), .b(nb_sr[0]), .cin(carry), .s(s), .cout(cout));
  // subtraction runs as a + ~b + ~bin; the final carry is the inverted borrow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_sr      <= '0;
      nb_sr     <= '0;
      d_sr      <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (io.in_valid) begin
            a_sr  <= io.a;
            nb_sr <= ~io.b;
            carry <= ~io.bin;
            cnt   <= '0;
            state <= S_RUN;
          end
        S_RUN: begin
          a_sr  <= a_sr >> 1;
          nb_sr <= nb_sr >> 1;
          d_sr  <= {s, d_sr[N-1:1]};
          carry <= cout;
          cnt   <= (cnt == LAST) ? cnt : cnt + 1'b1;
          state <= (cnt == LAST) ? S_DONE : S_RUN;
        end
        S_DONE:
          if (!out_valid) begin
            out_valid <= 1'b1;
            d         <= d_sr;
            bout      <= ~carry;
          end else if (io.out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
  assign io.in_ready  = state == S_IDLE;
  assign io.busy      = state != S_IDLE;
  assign io.out_valid = out_valid;
  assign io.d         = d;
  assign io.bout      = bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against a - b - bin
module tb_serial_subtractor;
  localparam int N = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  serial_subtractor_if #(.N(N)) io ();
  serial_subtractor #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else passed++;
  endtask
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                        input int stall, input bit pulse);
    int diff, n;
    logic [N-1:0] ed;
    logic eb;
    diff = int'(a) - int'(b) - int'(bin);
    ed = diff[N-1:0];
    eb = diff < 0;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.a = a;
    io.b = b;
    io.bin = bin;
    n = 0;
    while (!io.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready", io.in_ready, 1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.a = N'($urandom);
    io.b = N'($urandom);
    io.bin = 1'($urandom);
    n = 0;
    while (!io.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (pulse && n == 2) begin
        io.in_valid = 1'b1;
        io.a = ~a;
        io.b = a;
        io.bin = ~bin;
      end else if (pulse && n == 3) io.in_valid = 1'b0;
    end
    check("latency", n, N + 1);
    check("d", io.d, ed);
    check("bout", io.bout, eb);
    repeat (stall) begin
      @(posedge clk);
      #1;
      check("hold_valid", io.out_valid, 1);
      check("hold_d", io.d, ed);
      check("hold_bout", io.bout, eb);
    end
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    check("valid_fall", io.out_valid, 0);
    check("d_kept", io.d, ed);
    if (pulse) begin
      @(posedge clk);
      #1;
      check("pulse_ignored_busy", io.busy, 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    io.a = '0;
    io.b = '0;
    io.bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", io.in_ready, 1);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_busy", io.busy, 0);
    check("rst_d", io.d, 0);
    check("rst_bout", io.bout, 0);
    rst_n = 1'b1;
    run_op(6'd10, 6'd3, 1'b0, 0, 0);
    run_op(6'd3, 6'd10, 1'b0, 0, 0);
    run_op(6'd0, 6'd0, 1'b1, 0, 0);
    run_op(6'd63, 6'd63, 1'b0, 0, 0);
    run_op(6'd63, 6'd0, 1'b0, 0, 0);
    run_op(6'd45, 6'd17, 1'b1, 5, 1);
    @(negedge clk);
    io.in_valid = 1'b1;
    io.a = 6'd42;
    io.b = 6'd17;
    io.bin = 1'b0;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", io.out_valid, 0);
    check("abort_in_ready", io.in_ready, 1);
    check("abort_busy", io.busy, 0);
    check("abort_d", io.d, 0);
    check("abort_bout", io.bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(6'd20, 6'd5, 1'b0, 0, 0);
    for (int i = 0; i < 200; i++)
      run_op(N'($urandom), N'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
